// File: rtl/pad_hit_conditioner.sv
// Drum-pad input conditioner: per-pad two-flop synchronizer and debounce FSM,
// one-cycle hit pulses on accepted rising edges, sticky hit flags with overflow.
module pad_hit_conditioner #(
   parameter int NUM_PADS        = 8,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [31:0]         sensor_raw,
   input  logic                read_ack,
   output logic [31:0]         pad_state,
   output logic [NUM_PADS-1:0] hit_pulse,
   output logic [31:0]         hit_word,
   output logic                hit_valid
);

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      PEND_HIGH = 2'd1,
      HIGH      = 2'd2,
      PEND_LOW  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   logic [NUM_PADS-1:0] sync1_q, sync2_q;
   state_e              state_q [NUM_PADS];
   state_e              state_d [NUM_PADS];
   logic [CNT_W-1:0]    cnt_q   [NUM_PADS];
   logic [CNT_W-1:0]    cnt_d   [NUM_PADS];
   logic [NUM_PADS-1:0] hitPulse_q, hitPulse_d;
   logic [NUM_PADS-1:0] flags_q, flags_d;
   logic                overflow_q, overflow_d;
   logic [NUM_PADS-1:0] padLevel;
   logic                unused_raw;

   // Bits above NUM_PADS are deliberately ignored.
   assign unused_raw = ^sensor_raw;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sensor_raw[NUM_PADS-1:0];
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            state_q[i] <= LOW;
            cnt_q[i]   <= '0;
         end
         hitPulse_q <= '0;
      end else begin
         for (int i = 0; i < NUM_PADS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         hitPulse_q <= hitPulse_d;
      end
   end

   // A new level must be seen DEBOUNCE_CYCLES times in a row; any opposite
   // sample while pending returns to the old stable state.
   always_comb begin
      for (int i = 0; i < NUM_PADS; i++) begin
         state_d[i]    = state_q[i];
         cnt_d[i]      = cnt_q[i];
         hitPulse_d[i] = 1'b0;
         unique case (state_q[i])
            LOW: begin
               if (sync2_q[i]) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state_d[i]    = HIGH;
                     hitPulse_d[i] = 1'b1;
                  end else begin
                     state_d[i] = PEND_HIGH;
                     cnt_d[i]   = CntOne;
                  end
               end
            end
            PEND_HIGH: begin
               if (!sync2_q[i]) begin
                  state_d[i] = LOW;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CntLast) begin
                  state_d[i]    = HIGH;
                  cnt_d[i]      = '0;
                  hitPulse_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CntOne;
               end
            end
            HIGH: begin
               if (!sync2_q[i]) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state_d[i] = LOW;
                  end else begin
                     state_d[i] = PEND_LOW;
                     cnt_d[i]   = CntOne;
                  end
               end
            end
            PEND_LOW: begin
               if (sync2_q[i]) begin
                  state_d[i] = HIGH;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CntLast) begin
                  state_d[i] = LOW;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CntOne;
               end
            end
            default: begin
               state_d[i] = LOW;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_PADS; i++) begin
         padLevel[i] = (state_q[i] == HIGH) || (state_q[i] == PEND_LOW);
      end
   end

   // A fresh hit always wins over a simultaneous acknowledge so it is never lost.
   always_comb begin
      flags_d = hitPulse_q | (flags_q & ~{NUM_PADS{read_ack}});
      if (|(hitPulse_q & flags_q) && !read_ack) begin
         overflow_d = 1'b1;
      end else if (read_ack) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         flags_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         flags_q    <= flags_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      pad_state                 = '0;
      pad_state[NUM_PADS-1:0]   = padLevel;
      hit_word                  = '0;
      hit_word[NUM_PADS-1:0]    = flags_q;
      hit_word[31]              = overflow_q;
      hit_pulse                 = hitPulse_q;
      hit_valid                 = |flags_q;
   end

endmodule

// File: tb/tb_pad_hit_conditioner.sv
// Bench for pad_hit_conditioner: run-length reference model checked every cycle,
// plus directed scenarios with literal expectations at known edges.
module tb_pad_hit_conditioner;

   localparam int NP = 8;
   localparam int DC = 4;

   logic          clock;
   logic          resetn;
   logic [31:0]   sensor_raw;
   logic          read_ack;
   logic [31:0]   pad_state;
   logic [NP-1:0] hit_pulse;
   logic [31:0]   hit_word;
   logic          hit_valid;

   int testsRun;
   int testsFailed;
   bit checkEn;

   bit   s1 [NP];
   bit   s2 [NP];
   bit   runVal [NP];
   int   runLen [NP];
   bit   lvl [NP];
   logic [NP-1:0] mPulse;
   logic [NP-1:0] mFlags;
   bit   mOvf;

   pad_hit_conditioner #(
      .NUM_PADS(NP),
      .DEBOUNCE_CYCLES(DC),
      .CNT_W(4)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .sensor_raw(sensor_raw),
      .read_ack(read_ack),
      .pad_state(pad_state),
      .hit_pulse(hit_pulse),
      .hit_word(hit_word),
      .hit_valid(hit_valid)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic void modelReset();
      for (int i = 0; i < NP; i++) begin
         s1[i] = 1'b0; s2[i] = 1'b0; runVal[i] = 1'b0; runLen[i] = 0; lvl[i] = 1'b0;
      end
      mPulse = '0;
      mFlags = '0;
      mOvf   = 1'b0;
   endfunction

   // A level is adopted once the synchronized line has shown it DC times in a row.
   function automatic void modelStep(logic [31:0] raw, logic ack);
      logic [NP-1:0] newPulse;
      bit seen;
      newPulse = '0;
      for (int i = 0; i < NP; i++) begin
         seen  = s2[i];
         s2[i] = s1[i];
         s1[i] = raw[i];
         if (runLen[i] > 0 && seen == runVal[i]) begin
            if (runLen[i] < 1000) runLen[i] = runLen[i] + 1;
         end else begin
            runVal[i] = seen;
            runLen[i] = 1;
         end
         if (runLen[i] >= DC && runVal[i] != lvl[i]) begin
            lvl[i] = runVal[i];
            if (lvl[i]) newPulse[i] = 1'b1;
         end
      end
      if (|(mPulse & mFlags) && !ack) mOvf = 1'b1;
      else if (ack) mOvf = 1'b0;
      mFlags = mPulse | (ack ? '0 : mFlags);
      mPulse = newPulse;
   endfunction

   function automatic logic [31:0] modelLevel();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < NP; i++) v[i] = lvl[i];
      return v;
   endfunction

   initial begin
      modelReset();
      forever begin
         @(posedge clock or negedge resetn);
         if (!resetn) modelReset();
         else modelStep(sensor_raw, read_ack);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (checkEn && resetn) begin
            checkOutput("cyc_pad_state", pad_state, modelLevel());
            checkOutput("cyc_hit_pulse", 32'(hit_pulse), 32'(mPulse));
            checkOutput("cyc_hit_word", hit_word, {mOvf, 23'b0, mFlags});
            checkOutput("cyc_hit_valid", 32'(hit_valid), 32'(|mFlags));
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] raw, input logic ack, input int ticks);
      sensor_raw = raw;
      read_ack   = ack;
      repeat (ticks) @(negedge clock);
   endtask

   task automatic ackPulse();
      applyStimulus(sensor_raw, 1'b1, 1);
      read_ack = 1'b0;
   endtask

   task automatic checkAll(input string tag, input logic [31:0] ps, input logic [31:0] hp,
                           input logic [31:0] hw, input logic hv);
      checkOutput({tag, "_pad_state"}, pad_state, ps);
      checkOutput({tag, "_hit_pulse"}, 32'(hit_pulse), hp);
      checkOutput({tag, "_hit_word"}, hit_word, hw);
      checkOutput({tag, "_hit_valid"}, 32'(hit_valid), 32'(hv));
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      checkEn     = 1'b0;
      resetn      = 1'b0;
      sensor_raw  = '0;
      read_ack    = 1'b0;
      repeat (3) @(negedge clock);
      checkAll("reset_init", 32'h0, 32'h0, 32'h0, 1'b0);
      resetn  = 1'b1;
      checkEn = 1'b1;

      // Mid-run reset with pads high, then pad 0 held through release.
      applyStimulus(32'h0000_0081, 1'b0, 10);
      checkAll("pre_reset", 32'h81, 32'h0, 32'h81, 1'b1);
      #2 resetn = 1'b0;
      #1 checkAll("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clock);
      resetn = 1'b1;
      applyStimulus(32'h0000_0001, 1'b0, 5);
      checkAll("rel_e4", 32'h0, 32'h0, 32'h0, 1'b0);
      applyStimulus(32'h0000_0001, 1'b0, 1);
      checkAll("rel_e5", 32'h1, 32'h1, 32'h0, 1'b0);
      applyStimulus(32'h0000_0001, 1'b0, 1);
      checkAll("rel_e6", 32'h1, 32'h0, 32'h1, 1'b1);
      ackPulse();
      checkAll("rel_ack", 32'h1, 32'h0, 32'h0, 1'b0);

      // Glitch on pad 3 shorter than the debounce window.
      applyStimulus(32'h0000_0009, 1'b0, 3);
      applyStimulus(32'h0000_0001, 1'b0, 8);
      checkAll("glitch", 32'h1, 32'h0, 32'h0, 1'b0);

      // Bounce on pad 2: 1,0 then steady 1.
      applyStimulus(32'h0000_0005, 1'b0, 1);
      applyStimulus(32'h0000_0001, 1'b0, 1);
      applyStimulus(32'h0000_0005, 1'b0, 5);
      checkAll("bounce_e4", 32'h1, 32'h0, 32'h0, 1'b0);
      applyStimulus(32'h0000_0005, 1'b0, 1);
      checkAll("bounce_e5", 32'h5, 32'h4, 32'h0, 1'b0);
      applyStimulus(32'h0000_0005, 1'b0, 1);
      checkAll("bounce_e6", 32'h5, 32'h0, 32'h4, 1'b1);
      ackPulse();
      applyStimulus(32'h0, 1'b0, 8);
      checkAll("all_low", 32'h0, 32'h0, 32'h0, 1'b0);

      // Sticky flags on pads 1 and 5, cleared by read_ack.
      applyStimulus(32'h0000_0022, 1'b0, 7);
      checkAll("sticky_set", 32'h22, 32'h0, 32'h22, 1'b1);
      ackPulse();
      checkAll("sticky_clr", 32'h22, 32'h0, 32'h0, 1'b0);

      // Collision: pad 1 accepted in the cycle read_ack is high.
      applyStimulus(32'h0000_0020, 1'b0, 8);
      applyStimulus(32'h0000_0022, 1'b0, 6);
      checkAll("coll_pulse", 32'h22, 32'h2, 32'h0, 1'b0);
      ackPulse();
      checkAll("coll_after", 32'h22, 32'h0, 32'h2, 1'b1);
      applyStimulus(32'h0000_0020, 1'b0, 8);
      applyStimulus(32'h0000_0022, 1'b0, 7);
      checkAll("overflow", 32'h22, 32'h0, 32'h8000_0002, 1'b1);
      ackPulse();
      checkAll("ovf_clr", 32'h22, 32'h0, 32'h0, 1'b0);

      // Pad 4 released: level drops with no pulse, flag untouched.
      applyStimulus(32'h0000_0032, 1'b0, 8);
      checkAll("p4_high", 32'h32, 32'h0, 32'h10, 1'b1);
      applyStimulus(32'h0000_0022, 1'b0, 5);
      checkAll("p4_fall_e4", 32'h32, 32'h0, 32'h10, 1'b1);
      applyStimulus(32'h0000_0022, 1'b0, 1);
      checkAll("p4_fall_e5", 32'h22, 32'h0, 32'h10, 1'b1);
      applyStimulus(32'h0000_0022, 1'b0, 4);
      checkAll("p4_settled", 32'h22, 32'h0, 32'h10, 1'b1);

      // Upper raw bits must be ignored.
      applyStimulus(32'hFFFF_FF22, 1'b0, 10);
      checkAll("upper_ignored", 32'h22, 32'h0, 32'h10, 1'b1);

      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
